system_watchdog: RTL and testbench

- Watchdog that monitors a heartbeat ("pet") from the accelerometer/display datapath.
- If pets stop for TIMEOUT_CYCLES, it drives a multi-cycle kick pulse into system_reset_controller.kick, forcing a full system reset.
- Runs on the same clock as the datapath.
- Its reset must come from the power-on/external reset, never from the system reset it triggers, so that the kick pulse and status survive the reset they cause.

---
 rtl/system_watchdog_pkg.sv | 21 ++
 rtl/system_watchdog.sv | 133 +++++++++++++
 tb/tb_system_watchdog.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/system_watchdog_pkg.sv
// Shared types and sizing helpers for the system watchdog.
// Optional windowed mode is selected in the top with WATCHDOG_WINDOW_EN.
package system_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_KICK    = 2'd2,
        ST_HOLDOFF = 2'd3
    } wd_state_t;

    // One counter serves the timeout, kick width and holdoff phases.
    function automatic int calc_cnt_w(input int timeout_c, input int kick_c, input int hold_c);
        int m;
        m = timeout_c;
        if (kick_c > m) m = kick_c;
        if (hold_c > m) m = hold_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/system_watchdog.sv
// Heartbeat watchdog driving a multi-cycle kick into the system reset controller.
// Define WATCHDOG_WINDOW_EN to treat pets arriving before MIN_PET_CYCLES as a fault.
//
// state   | meaning
// IDLE    | disarmed, waiting for the first pet
// ARMED   | counting cycles since the last pet
// KICK    | kick output high, pulse width down-count
// HOLDOFF | system restarting, pets ignored
module system_watchdog
    import system_watchdog_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int KICK_CYCLES    = 4,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int MIN_PET_CYCLES = 16,
    parameter int COUNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pet,
    input  logic               clear_status,
    output logic               kick,
    output logic               timeout_flag,
    output logic               early_pet_flag,
    output logic [COUNT_W-1:0] kick_count,
    output logic               armed
);

    localparam int CNT_W = calc_cnt_w(TIMEOUT_CYCLES, KICK_CYCLES, HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] KICK_LOAD = CNT_W'(KICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] EARLY_LIM = CNT_W'(MIN_PET_CYCLES - 1);
`ifdef WATCHDOG_WINDOW_EN
    localparam bit WINDOW_EN = 1'b1;
`else
    localparam bit WINDOW_EN = 1'b0;
`endif

    wd_state_t          r_state;
    wd_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_kick;
    logic               r_armed;
    logic               r_timeout_flag;
    logic [COUNT_W-1:0] r_kick_count;
    logic               w_timeout;
    logic               w_early;
    logic               w_enter_kick;

    assign w_timeout = (r_state == ST_ARMED) && enable && !pet && (r_cnt == TO_LAST);
    assign w_early   = WINDOW_EN && (r_state == ST_ARMED) && enable && pet && (r_cnt < EARLY_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (enable && pet) w_state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (!enable)                    w_state_nxt = ST_IDLE;
                else if (w_timeout || w_early)  w_state_nxt = ST_KICK;
            end
            ST_KICK:    if (r_cnt == '0) w_state_nxt = ST_HOLDOFF;
            ST_HOLDOFF: if (r_cnt == '0) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // The same counter is loaded with the phase length on entry to KICK and HOLDOFF.
    always_comb begin
        w_cnt_nxt    = '0;
        w_enter_kick = (r_state == ST_ARMED) && (w_state_nxt == ST_KICK);
        case (r_state)
            ST_ARMED: begin
                if (w_enter_kick)                             w_cnt_nxt = KICK_LOAD;
                else if (pet || (w_state_nxt != ST_ARMED))    w_cnt_nxt = '0;
                else                                          w_cnt_nxt = r_cnt + 1'b1;
            end
            ST_KICK:    w_cnt_nxt = (r_cnt == '0) ? HOLD_LOAD : r_cnt - 1'b1;
            ST_HOLDOFF: w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
            default:    w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_kick         <= 1'b0;
            r_armed        <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_kick_count   <= '0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_kick         <= (w_state_nxt == ST_KICK);
            r_armed        <= (w_state_nxt == ST_ARMED);
            r_timeout_flag <= w_timeout || (r_timeout_flag && !clear_status);
            if (w_enter_kick && (r_kick_count != '1)) begin
                r_kick_count <= r_kick_count + 1'b1;
            end
        end
    end

`ifdef WATCHDOG_WINDOW_EN
    logic r_early_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_early_flag <= 1'b0;
        end else begin
            r_early_flag <= w_early || (r_early_flag && !clear_status);
        end
    end

    assign early_pet_flag = r_early_flag;
`else
    assign early_pet_flag = 1'b0;
`endif

    assign kick         = r_kick;
    assign timeout_flag = r_timeout_flag;
    assign kick_count   = r_kick_count;
    assign armed        = r_armed;

endmodule

// File: tb/tb_system_watchdog.sv
// Scoreboard bench for system_watchdog: stimulus queues per-cycle expectations, a monitor checks them.
// Windowed expectations apply when WATCHDOG_WINDOW_EN is defined.
module tb_system_watchdog;

    localparam int S_KICK  = 0;
    localparam int S_TFLAG = 1;
    localparam int S_EFLAG = 2;
    localparam int S_COUNT = 3;
    localparam int S_ARMED = 4;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pet;
    logic       clear_status;
    logic       kick;
    logic       timeout_flag;
    logic       early_pet_flag;
    logic [7:0] kick_count;
    logic       armed;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    system_watchdog #(
        .TIMEOUT_CYCLES (16),
        .KICK_CYCLES    (4),
        .HOLDOFF_CYCLES (8),
        .MIN_PET_CYCLES (4),
        .COUNT_W        (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .pet            (pet),
        .clear_status   (clear_status),
        .kick           (kick),
        .timeout_flag   (timeout_flag),
        .early_pet_flag (early_pet_flag),
        .kick_count     (kick_count),
        .armed          (armed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            S_KICK:  return "kick";
            S_TFLAG: return "timeout_flag";
            S_EFLAG: return "early_pet_flag";
            S_COUNT: return "kick_count";
            default: return "armed";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            S_KICK:  return int'(kick);
            S_TFLAG: return int'(timeout_flag);
            S_EFLAG: return int'(early_pet_flag);
            S_COUNT: return int'(kick_count);
            default: return int'(armed);
        endcase
    endfunction

    // Monitor: consume every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (sig_val(sb[i].sig) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cycle=%0d actual=%0d required=%0d",
                             sig_name(sb[i].sig), cyc, sig_val(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s cycle=%0d actual=unsampled required=%0d",
                         sig_name(sb[i].sig), sb[i].cyc, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int c, input int s, input int v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timer cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;
        int exp_count;

        reset = 1'b1;
        enable = 1'b0;
        pet = 1'b0;
        clear_status = 1'b0;
        step();
        step();

        // Reset held while enable/pet toggle.
        for (int i = 0; i < 3; i++) begin
            step();
            enable = (i % 2) == 1;
            pet    = (i != 1);
            push(cyc, S_KICK, 0);
            push(cyc, S_TFLAG, 0);
            push(cyc, S_EFLAG, 0);
            push(cyc, S_COUNT, 0);
            push(cyc, S_ARMED, 0);
        end
        step();
        reset = 1'b0;
        enable = 1'b1;
        pet = 1'b0;
        push(cyc, S_ARMED, 0);
        push(cyc, S_COUNT, 0);
        for (int k = 1; k <= 100; k++) begin
            step();
            push(cyc, S_KICK, 0);
            push(cyc, S_ARMED, 0);
        end

        // Single pet then silence: kick on cycles 17..20, IDLE at 29.
        step();
        pet = 1'b1;
        t = cyc;
        push(t + 1, S_ARMED, 1);
        for (int k = 1; k <= 31; k++) push(t + k, S_KICK, (k >= 17 && k <= 20) ? 1 : 0);
        push(t + 16, S_TFLAG, 0);
        push(t + 17, S_TFLAG, 1);
        push(t + 16, S_COUNT, 0);
        push(t + 17, S_COUNT, 1);
        push(t + 16, S_ARMED, 1);
        push(t + 17, S_ARMED, 0);
        push(t + 29, S_ARMED, 0);
        push(t + 30, S_ARMED, 0);
        for (int k = 1; k <= 31; k++) begin
            step();
            pet = (k >= 17 && k <= 28);
        end
        exp_count = 1;

        // Pet every 16 cycles: the boundary pet at counter 15 keeps it armed.
        step();
        pet = 1'b1;
        t = cyc;
        for (int k = 1; k <= 500; k++) begin
            push(t + k, S_KICK, 0);
            push(t + k, S_ARMED, 1);
        end
        for (int k = 1; k <= 500; k++) begin
            step();
            pet = (k % 16) == 0;
        end

        // Enable dropped at counter 10, then enabled without a pet.
        step();
        pet = 1'b1;
        t = cyc;
        for (int k = 1; k <= 70; k++) begin
            push(t + k, S_KICK, 0);
            push(t + k, S_ARMED, (k <= 11) ? 1 : 0);
        end
        for (int k = 1; k <= 70; k++) begin
            step();
            pet = 1'b0;
            enable = (k < 11) || (k > 40);
        end

        // Enable dropped on the second kick cycle: pulse still 4 wide.
        step();
        pet = 1'b1;
        enable = 1'b1;
        t = cyc;
        for (int k = 16; k <= 31; k++) push(t + k, S_KICK, (k >= 17 && k <= 20) ? 1 : 0);
        exp_count = 2;
        push(t + 17, S_COUNT, exp_count);
        push(t + 29, S_ARMED, 0);
        for (int k = 1; k <= 31; k++) begin
            step();
            pet = 1'b0;
            enable = (k < 18) || (k >= 30);
        end

        // Forced timeouts to saturation; clear/set collision on the last one.
        for (int i = 0; i < 260; i++) begin
            step();
            pet = 1'b1;
            clear_status = 1'b0;
            t = cyc;
            exp_count = (exp_count < 255) ? exp_count + 1 : 255;
            push(t + 16, S_KICK, 0);
            push(t + 17, S_KICK, 1);
            push(t + 20, S_KICK, 1);
            push(t + 21, S_KICK, 0);
            push(t + 17, S_COUNT, exp_count);
            if (i == 259) begin
                push(t + 17, S_TFLAG, 1);
                push(t + 22, S_TFLAG, 1);
                push(t + 23, S_TFLAG, 0);
            end
            for (int k = 1; k <= 28; k++) begin
                step();
                pet = 1'b0;
                clear_status = (i == 259) && (k == 16 || k == 22);
            end
        end

        // Pet at counter 2: early in windowed mode, legal otherwise.
        step();
        pet = 1'b1;
        clear_status = 1'b0;
        t = cyc;
        push(t + 3, S_KICK, 0);
        push(t + 4, S_TFLAG, 0);
        push(t + 4, S_COUNT, 255);
`ifdef WATCHDOG_WINDOW_EN
        push(t + 4, S_KICK, 1);
        push(t + 7, S_KICK, 1);
        push(t + 8, S_KICK, 0);
        push(t + 4, S_EFLAG, 1);
        push(t + 4, S_ARMED, 0);
`else
        push(t + 4, S_KICK, 0);
        push(t + 17, S_KICK, 0);
        push(t + 4, S_EFLAG, 0);
        push(t + 4, S_ARMED, 1);
`endif
        push(t + 19, S_ARMED, 0);
        for (int k = 1; k <= 22; k++) begin
            step();
            pet = (k == 3);
            enable = (k < 18);
        end

        // Pet at counter 3 is accepted.
        step();
        enable = 1'b1;
        pet = 1'b1;
        t = cyc;
        for (int k = 1; k <= 22; k++) push(t + k, S_KICK, 0);
        for (int k = 1; k <= 20; k++) push(t + k, S_ARMED, 1);
        push(t + 21, S_ARMED, 0);
        for (int k = 1; k <= 22; k++) begin
            step();
            pet = (k == 4);
            enable = (k < 20);
        end

        // clear_status alone drops both flags.
        step();
        pet = 1'b0;
        enable = 1'b1;
        clear_status = 1'b1;
        t = cyc;
`ifdef WATCHDOG_WINDOW_EN
        push(t, S_EFLAG, 1);
`endif
        push(t + 1, S_EFLAG, 0);
        push(t + 1, S_TFLAG, 0);
        push(t + 1, S_COUNT, 255);
        step();
        clear_status = 1'b0;
        for (int k = 0; k < 3; k++) step();

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s cycle=%0d actual=unsampled required=%0d",
                     sig_name(sb[0].sig), sb[0].cyc, sb[0].val);
            void'(sb.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
